// File: rtl/y86_fetch.sv
// Multi-cycle Y86-64 instruction fetch: byte-serial reads over req/ack,
// decoded fields held stable until downstream commits the next PC.
module y86_fetch #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req,
    output logic [63:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_err,
    input  logic        pc_load,
    input  logic [63:0] newPC,
    output logic [63:0] PC,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  rA,
    output logic [3:0]  rB,
    output logic [63:0] valC,
    output logic [63:0] valP,
    output logic        instr_valid,
    output logic        halted,
    output logic        instr_invalid,
    output logic        imem_error
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        VALID = 2'd1,
        STOP  = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] idx;
    logic [3:0] len;

    function automatic logic [3:0] ilen(input logic [3:0] ic);
        logic [3:0] n;
        case (ic)
            4'h2, 4'h6, 4'hA, 4'hB: n = 4'd2;
            4'h7, 4'h8:             n = 4'd9;
            4'h3, 4'h4, 4'h5:       n = 4'd10;
            default:                n = 4'd1;
        endcase
        return n;
    endfunction

    function automatic logic ifun_ok(input logic [3:0] ic,
                                     input logic [3:0] fn);
        logic ok;
        case (ic)
            4'h2, 4'h7:             ok = (fn <= 4'd6);
            4'h6:                   ok = (fn <= 4'd3);
            4'hC, 4'hD, 4'hE, 4'hF: ok = 1'b0;
            default:                ok = (fn == 4'd0);
        endcase
        return ok;
    endfunction

    // Byte-0 decode comes straight from the bus; later bytes use latched len.
    logic       first;
    logic [3:0] cur_icode;
    logic [3:0] cur_len;
    logic       last;
    logic       bad_op;
    logic       reg_byte;
    logic [3:0] coff;
    logic       c_byte;
    logic [2:0] kbyte;

    always_comb begin
        first     = (idx == 4'd0);
        cur_icode = first ? mem_rdata[7:4] : icode;
        cur_len   = first ? ilen(mem_rdata[7:4]) : len;
        last      = ((idx + 4'd1) == cur_len);
        bad_op    = first && !ifun_ok(mem_rdata[7:4], mem_rdata[3:0]);
        reg_byte  = (idx == 4'd1) && (len == 4'd2 || len == 4'd10);
        coff      = (len == 4'd9) ? 4'd1 : 4'd2;
        c_byte    = !first && (len >= 4'd9) && (idx >= coff);
        kbyte     = 3'(idx - coff);
    end

    assign mem_req  = rst_n && (state == FETCH);
    assign mem_addr = PC + {60'b0, idx};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= FETCH;
            idx           <= 4'd0;
            len           <= 4'd1;
            PC            <= RESET_PC;
            icode         <= 4'h0;
            ifun          <= 4'h0;
            rA            <= 4'hF;
            rB            <= 4'hF;
            valC          <= 64'h0;
            valP          <= RESET_PC;
            instr_valid   <= 1'b0;
            halted        <= 1'b0;
            instr_invalid <= 1'b0;
            imem_error    <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (mem_ack) begin
                        if (mem_err) begin
                            imem_error <= 1'b1;
                            state      <= STOP;
                        end else if (bad_op) begin
                            icode         <= mem_rdata[7:4];
                            ifun          <= mem_rdata[3:0];
                            instr_invalid <= 1'b1;
                            state         <= STOP;
                        end else begin
                            idx <= idx + 4'd1;
                            if (first) begin
                                icode <= mem_rdata[7:4];
                                ifun  <= mem_rdata[3:0];
                                len   <= cur_len;
                            end
                            if (reg_byte) begin
                                rA <= mem_rdata[7:4];
                                rB <= mem_rdata[3:0];
                            end
                            if (c_byte)
                                valC[{kbyte, 3'b000} +: 8] <= mem_rdata;
                            if (last) begin
                                valP        <= PC + {60'b0, cur_len};
                                instr_valid <= 1'b1;
                                if (cur_icode == 4'h0) begin
                                    halted <= 1'b1;
                                    state  <= STOP;
                                end else begin
                                    state <= VALID;
                                end
                            end
                        end
                    end
                end
                VALID: begin
                    if (pc_load) begin
                        PC          <= newPC;
                        idx         <= 4'd0;
                        valC        <= 64'h0;
                        instr_valid <= 1'b0;
                        rA          <= 4'hF;
                        rB          <= 4'hF;
                        state       <= FETCH;
                    end
                end
                STOP: begin
                    state <= STOP;
                end
                default: begin
                    state <= STOP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_y86_fetch.sv
// Bench for y86_fetch: byte memory model, random acks and instructions,
// expected fields computed from the instruction-format rules.
module tb_y86_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_rdata = 8'h0;
    logic        mem_err = 1'b0;
    logic        pc_load = 1'b0;
    logic [63:0] newPC = 64'h0;
    logic [63:0] PC;
    logic [3:0]  icode, ifun, rA, rB;
    logic [63:0] valC, valP;
    logic        instr_valid, halted, instr_invalid, imem_error;

    y86_fetch dut (
        .clk(clk), .rst_n(rst_n),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_err(mem_err),
        .pc_load(pc_load), .newPC(newPC),
        .PC(PC), .icode(icode), .ifun(ifun), .rA(rA), .rB(rB),
        .valC(valC), .valP(valP), .instr_valid(instr_valid),
        .halted(halted), .instr_invalid(instr_invalid),
        .imem_error(imem_error)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    logic [7:0] mem [logic [63:0]];
    int len_of[16] = '{1, 1, 2, 10, 10, 10, 2, 9, 9, 1, 2, 2, 1, 1, 1, 1};
    int maxf[16]   = '{0, 0, 6, 0, 0, 0, 3, 6, 0, 0, 0, 0, -1, -1, -1, -1};
    bit pat[4]     = '{1'b1, 1'b0, 1'b0, 1'b1};

    typedef struct {
        logic [3:0]  ic, fn, ra, rb;
        logic [63:0] vc, vp;
        int          n;
        bit          ok;
    } exp_t;

    function automatic logic [7:0] rd(input logic [63:0] a);
        return mem.exists(a) ? mem[a] : 8'h00;
    endfunction

    task automatic put_vec(input logic [63:0] a, input int n,
                           input logic [79:0] v);
        for (int k = 0; k < n; k++)
            mem[a + 64'(k)] = v[8*(n-1-k) +: 8];
    endtask

    task automatic put_rand(input logic [63:0] a);
        int ic;
        int n;
        ic = $urandom_range(1, 11);
        n  = len_of[ic];
        mem[a] = {4'(ic), 4'($urandom_range(0, maxf[ic]))};
        for (int k = 1; k < n; k++) mem[a + 64'(k)] = 8'($urandom);
    endtask

    function automatic exp_t model(input logic [63:0] pc);
        exp_t e;
        logic [7:0] b;
        int off;
        b    = rd(pc);
        e.ic = b[7:4];
        e.fn = b[3:0];
        e.n  = len_of[e.ic];
        e.ok = (e.ic < 4'hC) && (int'(e.fn) <= maxf[e.ic]);
        e.ra = 4'hF;
        e.rb = 4'hF;
        e.vc = 64'h0;
        if (e.n == 2 || e.n == 10) begin
            b    = rd(pc + 64'd1);
            e.ra = b[7:4];
            e.rb = b[3:0];
        end
        if (e.n >= 9) begin
            off = e.n - 8;
            for (int k = 0; k < 8; k++)
                e.vc = e.vc | (64'(rd(pc + 64'(off + k))) << (8 * k));
        end
        e.vp = pc + 64'(e.n);
        return e;
    endfunction

    // mode: 0 ack always, 1 random acks, 2 ack pattern 1,0,0,1
    task automatic run_fetch(input logic [63:0] pc, input int mode,
                             input int err_at, input bit loads);
        exp_t e;
        int stop_after;
        int acks;
        int edges;
        bit a;
        e = model(pc);
        stop_after = !e.ok ? 1 : (err_at >= 0 ? err_at + 1 : e.n);
        acks  = 0;
        edges = 0;
        while (acks < stop_after && edges < 200) begin
            @(negedge clk);
            chk("req_on", mem_req, 1);
            chk("addr", mem_addr, pc + 64'(acks));
            a = (mode == 0) ? 1'b1 :
                (mode == 2) ? pat[edges % 4] : ($urandom_range(0, 2) != 0);
            mem_ack   = a;
            mem_rdata = a ? rd(pc + 64'(acks)) : 8'($urandom);
            mem_err   = a ? (acks == err_at) : 1'($urandom);
            if (loads) begin
                pc_load = 1'($urandom);
                newPC   = {$urandom, $urandom};
            end
            @(posedge clk);
            #1;
            edges++;
            if (a) acks++;
            mem_ack = 1'b0;
            mem_err = 1'b0;
            pc_load = 1'b0;
            if (acks < stop_after) chk("valid_early", instr_valid, 0);
        end
        if (acks < stop_after) chk("timeout", 0, 1);
        if (mode == 0) chk("edges", 64'(edges), 64'(stop_after));
        chk("req_off", mem_req, 0);
        chk("pc_hold", PC, pc);
        if (err_at >= 0) begin
            chk("imem_error", imem_error, 1);
            chk("err_valid", instr_valid, 0);
        end else if (!e.ok) begin
            chk("instr_invalid", instr_invalid, 1);
            chk("inv_valid", instr_valid, 0);
        end else begin
            chk("instr_valid", instr_valid, 1);
            chk("icode", icode, e.ic);
            chk("ifun", ifun, e.fn);
            chk("rA", rA, e.ra);
            chk("rB", rB, e.rb);
            chk("valC", valC, e.vc);
            chk("valP", valP, e.vp);
            chk("halted", halted, e.ic == 4'h0);
        end
    endtask

    task automatic idle_check(input int n, input bit loads);
        logic [63:0] pc0;
        pc0 = PC;
        repeat (n) begin
            @(negedge clk);
            mem_ack = 1'b1;
            pc_load = loads;
            newPC   = {$urandom, $urandom};
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
            pc_load = 1'b0;
            chk("idle_req", mem_req, 0);
            chk("idle_pc", PC, pc0);
        end
    endtask

    task automatic do_load(input logic [63:0] a);
        @(negedge clk);
        pc_load = 1'b1;
        newPC   = a;
        @(posedge clk);
        #1;
        pc_load = 1'b0;
        chk("ld_pc", PC, a);
        chk("ld_valid", instr_valid, 0);
        chk("ld_ra", rA, 4'hF);
        chk("ld_rb", rB, 4'hF);
        chk("ld_valc", valC, 0);
        chk("ld_req", mem_req, 1);
        chk("ld_addr", mem_addr, a);
    endtask

    task automatic reset_checks();
        chk("rst_req", mem_req, 0);
        chk("rst_pc", PC, 0);
        chk("rst_icode", icode, 0);
        chk("rst_ifun", ifun, 0);
        chk("rst_ra", rA, 4'hF);
        chk("rst_rb", rB, 4'hF);
        chk("rst_valc", valC, 0);
        chk("rst_valp", valP, 0);
        chk("rst_status",
            {60'b0, instr_valid, halted, instr_invalid, imem_error}, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        mem_ack = 1'b0;
        pc_load = 1'b0;
        #1;
        reset_checks();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_req", mem_req, 1);
        chk("rel_addr", mem_addr, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] a;
        put_vec(64'h0,   10, 80'h30F20A00000000000000);
        put_vec(64'h40,  2,  80'h6023);
        put_vec(64'h20,  9,  80'h700001000000000000);
        do_reset();
        run_fetch(64'h0, 0, -1, 1'b0);
        idle_check(2, 1'b0);
        do_load(64'h40);
        run_fetch(64'h40, 2, -1, 1'b0);
        do_load(64'h20);
        run_fetch(64'h20, 0, -1, 1'b0);
        for (int i = 0; i < 30; i++) begin
            a = {$urandom, $urandom};
            put_rand(a);
            do_load(a);
            run_fetch(a, 1, -1, 1'b1);
        end
        a = 64'hFFFF_FFFF_FFFF_FFFA;
        put_vec(a, 10, 80'h30F2_8877665544332211);
        do_load(a);
        run_fetch(a, 1, -1, 1'b0);
        put_vec(64'h500, 1, 80'h00);
        do_load(64'h500);
        run_fetch(64'h500, 1, -1, 1'b0);
        idle_check(3, 1'b1);
        chk("halt_stay", halted, 1);
        chk("halt_valid", instr_valid, 1);

        put_vec(64'h0, 10, 80'h30F20A00000000000000);
        put_vec(64'h200, 1, 80'hC0);
        put_vec(64'h210, 2, 80'h6F12);
        put_vec(64'h300, 10, 80'h40120800000000000000);
        do_reset();
        run_fetch(64'h0, 1, -1, 1'b0);
        do_load(64'h200);
        run_fetch(64'h200, 0, -1, 1'b0);
        idle_check(3, 1'b1);
        do_reset();
        run_fetch(64'h0, 0, -1, 1'b0);
        do_load(64'h210);
        run_fetch(64'h210, 1, -1, 1'b0);
        idle_check(3, 1'b1);
        do_reset();
        run_fetch(64'h0, 0, -1, 1'b0);
        do_load(64'h300);
        run_fetch(64'h300, 0, 3, 1'b0);
        idle_check(3, 1'b1);

        do_reset();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            mem_ack   = 1'b1;
            mem_rdata = rd(64'(k));
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
        end
        chk("mid_icode", icode, 4'h3);
        #2;
        rst_n = 1'b0;
        #1;
        reset_checks();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mid_rel_addr", mem_addr, 0);
        run_fetch(64'h0, 0, -1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
